// File: rtl/dm_sba_pkg.sv
// Shared types and constants for the debug-module system bus access block.
package dm_sba_pkg;

    localparam int unsigned DMI_AW = 7;
    localparam int unsigned XLEN   = 32;

    localparam logic [DMI_AW-1:0] DMI_SBCS    = 7'h38;
    localparam logic [DMI_AW-1:0] DMI_SBADDR0 = 7'h39;
    localparam logic [DMI_AW-1:0] DMI_SBDATA0 = 7'h3C;

    localparam logic [2:0] SBERR_NONE    = 3'd0;
    localparam logic [2:0] SBERR_TIMEOUT = 3'd1;
    localparam logic [2:0] SBERR_BADADDR = 3'd2;
    localparam logic [2:0] SBERR_ALIGN   = 3'd3;
    localparam logic [2:0] SBERR_SIZE    = 3'd4;

    typedef struct packed {
        logic [2:0] sbversion;
        logic [5:0] zero0;
        logic       sbbusyerror;
        logic       sbbusy;
        logic       sbreadonaddr;
        logic [2:0] sbaccess;
        logic       sbautoincrement;
        logic       sbreadondata;
        logic [2:0] sberror;
        logic [6:0] sbasize;
        logic       sbaccess128;
        logic       sbaccess64;
        logic       sbaccess32;
        logic       sbaccess16;
        logic       sbaccess8;
    } sbcs_t;

    typedef enum logic {
        SBA_IDLE = 1'b0,
        SBA_REQ  = 1'b1
    } sba_state_e;

    // True when the byte offset is not a multiple of the access size.
    function automatic logic sba_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd1:    sba_misaligned = off[0];
            2'd2:    sba_misaligned = |off;
            default: sba_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_sba_if.sv
// System-bus master port of the SBA controller.
interface dm_sba_if;
    import dm_sba_pkg::*;

    logic            sb_req;
    logic            sb_we;
    logic [XLEN-1:0] sb_addr;
    logic [1:0]      sb_size;
    logic [XLEN-1:0] sb_wdata;
    logic [XLEN-1:0] sb_rdata;
    logic            sb_ack;
    logic            sb_err;

    modport master (
        output sb_req, sb_we, sb_addr, sb_size, sb_wdata,
        input  sb_rdata, sb_ack, sb_err
    );

    modport slave (
        input  sb_req, sb_we, sb_addr, sb_size, sb_wdata,
        output sb_rdata, sb_ack, sb_err
    );
endinterface

// File: rtl/dm_sba_lane.sv
// Byte-lane alignment: shifts write data up to its lane, extracts read data down.
module sba_lane
    import dm_sba_pkg::*;
(
    input  logic [1:0]      i_wsize,
    input  logic [1:0]      i_woff,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_wdata,
    input  logic [1:0]      i_rsize,
    input  logic [1:0]      i_roff,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_rdata
);
    logic [XLEN-1:0] w_rshift;

    assign o_wdata  = i_wdata << {i_woff, 3'b000};
    assign w_rshift = i_rdata >> {i_roff, 3'b000};

    // Write size only matters for the pre-check; the bus masks lanes by sb_size.
    logic [1:0] w_wsize_unused;
    assign w_wsize_unused = i_wsize;

    always_comb begin
        case (i_rsize)
            2'd0:    o_rdata = XLEN'(w_rshift[7:0]);
            2'd1:    o_rdata = XLEN'(w_rshift[15:0]);
            default: o_rdata = w_rshift;
        endcase
    end
endmodule

// File: rtl/dm_sba.sv
// SBA controller: owns sbcs/sbaddress0/sbdata0 and sequences one bus access at a time.
module dm_sba
    import dm_sba_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmactive,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [DMI_AW-1:0] reg_addr,
    input  logic [XLEN-1:0]   reg_wdata,
    output logic [XLEN-1:0]   sbcs_o,
    output logic [XLEN-1:0]   sbaddress0_o,
    output logic [XLEN-1:0]   sbdata0_o,
    dm_sba_if.master          sb
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

    sba_state_e      r_state, w_state;
    logic            r_busyerr, w_busyerr;
    logic            r_busy, w_busy;
    logic            r_readonaddr, w_readonaddr;
    logic [2:0]      r_access, w_access;
    logic            r_autoinc, w_autoinc;
    logic            r_readondata, w_readondata;
    logic [2:0]      r_sberror, w_sberror;
    logic [XLEN-1:0] r_addr, w_addr;
    logic [XLEN-1:0] r_data, w_data;
    logic            r_we, w_we;
    logic [1:0]      r_size, w_size;
    logic [XLEN-1:0] r_wdata, w_wdata;
    logic [TMO_W-1:0] r_tmo, w_tmo;

    logic            w_wr_sbcs, w_wr_addr, w_wr_data, w_rd_data;
    logic [XLEN-1:0] w_trig_addr, w_trig_data, w_lane_wdata, w_lane_rdata;
    sbcs_t           w_sbcs;

    // A coincident write wins over the read side effect.
    assign w_wr_sbcs   = reg_wr && (reg_addr == DMI_SBCS);
    assign w_wr_addr   = reg_wr && (reg_addr == DMI_SBADDR0);
    assign w_wr_data   = reg_wr && (reg_addr == DMI_SBDATA0);
    assign w_rd_data   = reg_rd && !reg_wr && (reg_addr == DMI_SBDATA0);
    assign w_trig_addr = w_wr_addr ? reg_wdata : r_addr;
    assign w_trig_data = w_wr_data ? reg_wdata : r_data;

    sba_lane u_lane (
        .i_wsize (r_access[1:0]),
        .i_woff  (w_trig_addr[1:0]),
        .i_wdata (w_trig_data),
        .o_wdata (w_lane_wdata),
        .i_rsize (r_size),
        .i_roff  (r_addr[1:0]),
        .i_rdata (sb.sb_rdata),
        .o_rdata (w_lane_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SBA_IDLE;
            r_busyerr    <= 1'b0;
            r_busy       <= 1'b0;
            r_readonaddr <= 1'b0;
            r_access     <= 3'd0;
            r_autoinc    <= 1'b0;
            r_readondata <= 1'b0;
            r_sberror    <= SBERR_NONE;
            r_addr       <= '0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_wdata      <= '0;
            r_tmo        <= '0;
        end else begin
            r_state      <= w_state;
            r_busyerr    <= w_busyerr;
            r_busy       <= w_busy;
            r_readonaddr <= w_readonaddr;
            r_access     <= w_access;
            r_autoinc    <= w_autoinc;
            r_readondata <= w_readondata;
            r_sberror    <= w_sberror;
            r_addr       <= w_addr;
            r_data       <= w_data;
            r_we         <= w_we;
            r_size       <= w_size;
            r_wdata      <= w_wdata;
            r_tmo        <= w_tmo;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_busyerr    = r_busyerr;
        w_busy       = r_busy;
        w_readonaddr = r_readonaddr;
        w_access     = r_access;
        w_autoinc    = r_autoinc;
        w_readondata = r_readondata;
        w_sberror    = r_sberror;
        w_addr       = r_addr;
        w_data       = r_data;
        w_we         = r_we;
        w_size       = r_size;
        w_wdata      = r_wdata;
        w_tmo        = r_tmo;

        if (w_wr_sbcs) begin
            w_busyerr    = r_busyerr & ~reg_wdata[22];
            w_sberror    = r_sberror & ~reg_wdata[14:12];
            w_readonaddr = reg_wdata[20];
            w_access     = reg_wdata[19:17];
            w_autoinc    = reg_wdata[16];
            w_readondata = reg_wdata[15];
        end

        case (r_state)
            SBA_IDLE: begin
                if (w_wr_addr) w_addr = reg_wdata;
                if (w_wr_data) w_data = reg_wdata;
                if ((w_wr_data || (w_wr_addr && r_readonaddr) || (w_rd_data && r_readondata))
                    && !r_busyerr && (r_sberror == SBERR_NONE)) begin
                    if (r_access > 3'd2) begin
                        w_sberror = SBERR_SIZE;
                    end else if (sba_misaligned(r_access[1:0], w_trig_addr[1:0])) begin
                        w_sberror = SBERR_ALIGN;
                    end else begin
                        w_state = SBA_REQ;
                        w_busy  = 1'b1;
                        w_we    = w_wr_data;
                        w_size  = r_access[1:0];
                        w_wdata = w_lane_wdata;
                        w_tmo   = '0;
                    end
                end
            end
            SBA_REQ: begin
                if (w_wr_addr || w_wr_data || w_rd_data) w_busyerr = 1'b1;
                if (sb.sb_ack) begin
                    if (!r_we)     w_data = w_lane_rdata;
                    if (r_autoinc) w_addr = r_addr + (XLEN'(1) << r_size);
                    w_busy  = 1'b0;
                    w_we    = 1'b0;
                    w_state = SBA_IDLE;
                end else if (sb.sb_err) begin
                    w_sberror = SBERR_BADADDR;
                    w_busy    = 1'b0;
                    w_we      = 1'b0;
                    w_state   = SBA_IDLE;
                end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_sberror = SBERR_TIMEOUT;
                    w_busy    = 1'b0;
                    w_we      = 1'b0;
                    w_state   = SBA_IDLE;
                end else begin
                    w_tmo = r_tmo + TMO_W'(1);
                end
            end
            default: w_state = SBA_IDLE;
        endcase

        // dmactive low holds everything at its reset value.
        if (!dmactive) begin
            w_state      = SBA_IDLE;
            w_busyerr    = 1'b0;
            w_busy       = 1'b0;
            w_readonaddr = 1'b0;
            w_access     = 3'd0;
            w_autoinc    = 1'b0;
            w_readondata = 1'b0;
            w_sberror    = SBERR_NONE;
            w_addr       = '0;
            w_data       = '0;
            w_we         = 1'b0;
            w_size       = 2'd0;
            w_wdata      = '0;
            w_tmo        = '0;
        end
    end

    always_comb begin
        w_sbcs                 = '0;
        w_sbcs.sbversion       = 3'd1;
        w_sbcs.sbbusyerror     = r_busyerr;
        w_sbcs.sbbusy          = r_busy;
        w_sbcs.sbreadonaddr    = r_readonaddr;
        w_sbcs.sbaccess        = r_access;
        w_sbcs.sbautoincrement = r_autoinc;
        w_sbcs.sbreadondata    = r_readondata;
        w_sbcs.sberror         = r_sberror;
        w_sbcs.sbasize         = 7'(XLEN);
        w_sbcs.sbaccess32      = 1'b1;
        w_sbcs.sbaccess16      = 1'b1;
        w_sbcs.sbaccess8       = 1'b1;
    end

    assign sbcs_o       = w_sbcs;
    assign sbaddress0_o = r_addr;
    assign sbdata0_o    = r_data;

    assign sb.sb_req   = (r_state == SBA_REQ);
    assign sb.sb_we    = r_we;
    assign sb.sb_addr  = r_addr;
    assign sb.sb_size  = r_size;
    assign sb.sb_wdata = r_wdata;
endmodule

// File: tb/tb_dm_sba.sv
// Directed bench for dm_sba: register triggers, lane handling, errors, timeout and reset.
module tb_dm_sba;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmactive;
    logic        reg_wr, reg_rd;
    logic [6:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] sbcs_o, sbaddress0_o, sbdata0_o;
    int          n_tests = 0;
    int          n_fail  = 0;

    dm_sba_if sb_if ();

    dm_sba u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmactive     (dmactive),
        .reg_wr       (reg_wr),
        .reg_rd       (reg_rd),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .sbcs_o       (sbcs_o),
        .sbaddress0_o (sbaddress0_o),
        .sbdata0_o    (sbdata0_o),
        .sb           (sb_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_wr = 1'b0;
    endtask

    task automatic dmi_read(input logic [6:0] a);
        @(negedge clk);
        reg_rd = 1'b1; reg_addr = a;
        @(negedge clk);
        reg_rd = 1'b0;
    endtask

    task automatic bus_ack(input logic [31:0] rd);
        sb_if.sb_ack = 1'b1; sb_if.sb_rdata = rd;
        @(negedge clk);
        sb_if.sb_ack = 1'b0; sb_if.sb_rdata = '0;
    endtask

    task automatic bus_err();
        sb_if.sb_err = 1'b1;
        @(negedge clk);
        sb_if.sb_err = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; dmactive = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
        reg_addr = '0; reg_wdata = '0;
        sb_if.sb_rdata = '0; sb_if.sb_ack = 1'b0; sb_if.sb_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sbcs", sbcs_o, 32'h2000_0407);
        check("rst_addr", sbaddress0_o, 32'h0);
        check("rst_data", sbdata0_o, 32'h0);
        check("rst_req", 32'(sb_if.sb_req), 32'h0);
        check("rst_we", 32'(sb_if.sb_we), 32'h0);
        rst_n = 1'b1; dmactive = 1'b1;

        // Aligned word write
        dmi_write(7'h38, 32'h0004_0000);
        dmi_write(7'h39, 32'h0000_1000);
        check("t1_noreq", 32'(sb_if.sb_req), 32'h0);
        dmi_write(7'h3C, 32'hDEAD_BEEF);
        check("t1_req", 32'(sb_if.sb_req), 32'h1);
        check("t1_we", 32'(sb_if.sb_we), 32'h1);
        check("t1_addr", sb_if.sb_addr, 32'h0000_1000);
        check("t1_size", 32'(sb_if.sb_size), 32'h2);
        check("t1_wdata", sb_if.sb_wdata, 32'hDEAD_BEEF);
        check("t1_busy", sbcs_o, 32'h2024_0407);
        bus_ack(32'h0);
        check("t1_done_req", 32'(sb_if.sb_req), 32'h0);
        check("t1_done_sbcs", sbcs_o, 32'h2004_0407);

        // Byte read at offset 3 triggered by address write
        dmi_write(7'h38, 32'h0010_0000);
        dmi_write(7'h39, 32'h0000_1003);
        check("t2_req", 32'(sb_if.sb_req), 32'h1);
        check("t2_we", 32'(sb_if.sb_we), 32'h0);
        check("t2_size", 32'(sb_if.sb_size), 32'h0);
        bus_ack(32'hAB00_0000);
        check("t2_data", sbdata0_o, 32'h0000_00AB);

        // Read-on-data with autoincrement wrapping the address
        dmi_write(7'h38, 32'h0005_8000);
        dmi_write(7'h39, 32'hFFFF_FFFC);
        check("t3_noreq", 32'(sb_if.sb_req), 32'h0);
        dmi_read(7'h3C);
        check("t3_addr0", sb_if.sb_addr, 32'hFFFF_FFFC);
        bus_ack(32'h1122_3344);
        check("t3_data0", sbdata0_o, 32'h1122_3344);
        check("t3_wrap", sbaddress0_o, 32'h0);
        dmi_read(7'h3C);
        check("t3_addr1", sb_if.sb_addr, 32'h0);
        bus_ack(32'h5566_7788);
        check("t3_data1", sbdata0_o, 32'h5566_7788);
        check("t3_inc", sbaddress0_o, 32'h4);

        // Busy violation then W1C
        dmi_write(7'h38, 32'h0004_0000);
        dmi_write(7'h3C, 32'h1234_5678);
        dmi_write(7'h3C, 32'hCAFE_F00D);
        check("t4_busyerr", sbcs_o, 32'h2064_0407);
        check("t4_wdata", sb_if.sb_wdata, 32'h1234_5678);
        bus_ack(32'hFFFF_FFFF);
        check("t4_data", sbdata0_o, 32'h1234_5678);
        dmi_write(7'h38, 32'h0044_0000);
        check("t4_clear", sbcs_o, 32'h2004_0407);

        // Alignment, size and timeout errors
        dmi_write(7'h38, 32'h0002_0000);
        dmi_write(7'h39, 32'h0000_1001);
        dmi_write(7'h3C, 32'h0000_0001);
        check("t5_align", sbcs_o, 32'h2002_3407);
        check("t5_align_req", 32'(sb_if.sb_req), 32'h0);
        dmi_write(7'h38, 32'h0006_7000);
        dmi_write(7'h3C, 32'h0000_0001);
        check("t5_size", sbcs_o, 32'h2006_4407);
        check("t5_size_req", 32'(sb_if.sb_req), 32'h0);
        dmi_write(7'h38, 32'h0004_7000);
        dmi_write(7'h39, 32'h0000_2000);
        dmi_write(7'h3C, 32'h0000_0000);
        n = 0;
        while (sb_if.sb_req && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t5_tmo_cycles", 32'(n), 32'd256);
        check("t5_tmo_sbcs", sbcs_o, 32'h2004_1407);
        dmi_write(7'h38, 32'h0004_7000);

        // Bus error on an autoincrementing read leaves the address alone
        dmi_write(7'h38, 32'h0015_0000);
        dmi_write(7'h39, 32'h0000_3000);
        check("t6_req", 32'(sb_if.sb_req), 32'h1);
        bus_err();
        check("t6_sbcs", sbcs_o, 32'h2015_2407);
        check("t6_addr", sbaddress0_o, 32'h0000_3000);

        // Async reset mid-access
        dmi_write(7'h38, 32'h0015_7000);
        dmi_write(7'h39, 32'h0000_4000);
        check("t7_req", 32'(sb_if.sb_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_req_drop", 32'(sb_if.sb_req), 32'h0);
        check("t7_sbcs", sbcs_o, 32'h2000_0407);
        check("t7_addr", sbaddress0_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_ack(32'hFFFF_FFFF);
        check("t7_late_ack", sbdata0_o, 32'h0);
        check("t7_late_req", 32'(sb_if.sb_req), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
